// File: rtl/contrast_stretcher.sv
// contrast_stretcher: linear contrast stretch of a luma pixel stream.
//   data_out = sat((data_in - min) * 255 / diff), with the reciprocal gain
//   computed once per frame by a bit-serial restoring divider. New parameters
//   are held pending and applied from the first pixel of the next frame.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   stats_update, min_in, diff_in  per-frame statistics strobe and values
//   sop_in, eop_in, valid_in, data_in      input pixel stream
//   sop_out, eop_out, valid_out, data_out  output stream, 3-cycle latency
//   div_busy                     divider running
module contrast_stretcher #(
    parameter int unsigned W     = 8,
    parameter int unsigned LINES = 720
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         stats_update,
    input  logic [W-1:0] min_in,
    input  logic [W-1:0] diff_in,
    input  logic         sop_in,
    input  logic         eop_in,
    input  logic         valid_in,
    input  logic [W-1:0] data_in,
    output logic         sop_out,
    output logic         eop_out,
    output logic         valid_out,
    output logic [W-1:0] data_out,
    output logic         div_busy
);

    localparam int unsigned GW  = W + 8;
    localparam int unsigned PW  = W + GW;
    localparam int unsigned LCW = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int unsigned CW  = $clog2(GW);

    localparam logic [GW-1:0]  DIVIDEND = {{W{1'b1}}, 8'h00};
    localparam logic [GW-1:0]  GAIN_ONE = GW'(256);
    localparam logic [LCW-1:0] LINE_LAST = LCW'(LINES - 1);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(GW - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [LCW-1:0]  line_cnt_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    min_q;
    logic [W-1:0]    diff_q;
    logic [GW-1:0]   dvd_q;
    logic [W-1:0]    rem_q;
    logic [GW-2:0]   quo_q;
    logic            busy_q;

    logic            pend_q;
    logic [W-1:0]    min_pend_q;
    logic [GW-1:0]   gain_pend_q;
    logic [W-1:0]    min_act_q;
    logic [GW-1:0]   gain_act_q;

    logic [W-1:0]    sub_q;
    logic [GW-1:0]   gain_s1_q;
    logic [PW-1:0]   prod_q;
    logic [W-1:0]    data_s3_q;
    logic [2:0]      sop_pipe_q;
    logic [2:0]      eop_pipe_q;
    logic [2:0]      valid_pipe_q;

    // One restoring-division step: shift in next dividend bit, subtract if it fits
    logic [W:0]      rem_sh_d;
    logic            q_bit_d;
    logic [W-1:0]    rem_d;
    logic [GW-1:0]   quo_d;

    assign rem_sh_d = {rem_q, dvd_q[GW-1]};
    assign q_bit_d  = (rem_sh_d >= {1'b0, diff_q});
    assign rem_d    = q_bit_d ? (rem_sh_d[W-1:0] - diff_q) : rem_sh_d[W-1:0];
    assign quo_d    = {quo_q, q_bit_d};

    // Frame-boundary swap; the sop pixel itself sees the swapped parameters
    logic            swap_d;
    logic [W-1:0]    min_use_d;
    logic [GW-1:0]   gain_use_d;
    logic [W-1:0]    sub_d;
    logic [PW-1:0]   prod_d;
    logic [PW-1:0]   scaled_d;
    logic            start_d;
    logic            zero_d;

    assign swap_d     = sop_in && (line_cnt_q == '0) && pend_q;
    assign min_use_d  = swap_d ? min_pend_q  : min_act_q;
    assign gain_use_d = swap_d ? gain_pend_q : gain_act_q;
    assign sub_d      = (data_in >= min_use_d) ? (data_in - min_use_d) : '0;
    assign prod_d     = PW'(sub_q) * PW'(gain_s1_q);
    assign scaled_d   = (prod_q + PW'(128)) >> 8;
    assign start_d    = stats_update && (diff_in != '0);
    assign zero_d     = stats_update && (diff_in == '0);

    // Line counter, divider FSM, parameter registers and pixel pipeline
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            line_cnt_q   <= '0;
            cnt_q        <= '0;
            min_q        <= '0;
            diff_q       <= '0;
            dvd_q        <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            busy_q       <= 1'b0;
            pend_q       <= 1'b0;
            min_pend_q   <= '0;
            gain_pend_q  <= GAIN_ONE;
            min_act_q    <= '0;
            gain_act_q   <= GAIN_ONE;
            sub_q        <= '0;
            gain_s1_q    <= '0;
            prod_q       <= '0;
            data_s3_q    <= '0;
            sop_pipe_q   <= '0;
            eop_pipe_q   <= '0;
            valid_pipe_q <= '0;
        end else begin
            if (eop_in) begin
                line_cnt_q <= (line_cnt_q == LINE_LAST) ? '0 : line_cnt_q + LCW'(1);
            end

            // Swap consumes the old pending set; a new result below re-arms pending
            if (swap_d) begin
                min_act_q  <= min_pend_q;
                gain_act_q <= gain_pend_q;
                pend_q     <= 1'b0;
            end

            if (start_d) begin
                // Any strobe (re)starts the division; an in-flight result is dropped
                state_q <= S_DIV;
                busy_q  <= 1'b1;
                min_q   <= min_in;
                diff_q  <= diff_in;
                dvd_q   <= DIVIDEND;
                rem_q   <= '0;
                quo_q   <= '0;
                cnt_q   <= '0;
            end else if (zero_d) begin
                // Flat frame: fall back to pass-through
                state_q     <= S_IDLE;
                busy_q      <= 1'b0;
                min_pend_q  <= '0;
                gain_pend_q <= GAIN_ONE;
                pend_q      <= 1'b1;
            end else begin
                case (state_q)
                    S_DIV: begin
                        dvd_q <= {dvd_q[GW-2:0], 1'b0};
                        rem_q <= rem_d;
                        quo_q <= quo_d[GW-2:0];
                        if (cnt_q == CNT_LAST) begin
                            state_q     <= S_DONE;
                            busy_q      <= 1'b0;
                            gain_pend_q <= quo_d;
                            min_pend_q  <= min_q;
                            pend_q      <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end

            // S1: offset removal; gain travels with the pixel into S2
            sub_q     <= sub_d;
            gain_s1_q <= gain_use_d;
            // S2: scale
            prod_q    <= prod_d;
            // S3: round and saturate
            data_s3_q <= (scaled_d > PW'({W{1'b1}})) ? {W{1'b1}} : scaled_d[W-1:0];

            sop_pipe_q   <= {sop_pipe_q[1:0], sop_in};
            eop_pipe_q   <= {eop_pipe_q[1:0], eop_in};
            valid_pipe_q <= {valid_pipe_q[1:0], valid_in};
        end
    end

    assign sop_out   = sop_pipe_q[2];
    assign eop_out   = eop_pipe_q[2];
    assign valid_out = valid_pipe_q[2];
    assign data_out  = data_s3_q;
    assign div_busy  = busy_q;

endmodule
